key_debounce_bank: RTL
======================

# key_debounce_bank

Parametrised multi-channel push-button conditioner that sits between the board KEY/SW pins and the game control logic. It replaces per-signal single-channel debouncers. Per channel it synchronises, debounces and polarity-normalises a raw input, then emits a stable level plus single-cycle press/release events. It also tracks the most recently pressed channel, so direction logic can consume one index instead of a raw mask. Optional auto-repeat generates periodic press events while a key is held.

## Interface
- N_CH, 4, number of input channels (1..16)
- DB_CYCLES, 16, consecutive mismatching cycles required to accept a new level (≥2)
- ACTIVE_LOW, 1, 1: raw pin low means pressed; 0: raw high means pressed
- REPEAT_DELAY, 64, cycles from press event to first repeat event (≥2, used only with auto-repeat)
- REPEAT_RATE, 16, cycles between subsequent repeat events (≥2, used only with auto-repeat)
- IDX_W, $clog2(N_CH) (min 1), width of last_idx
- clk  in  1  system clock
- rst_flag  in  1  reset, asynchronous, active-high
- raw_in  in  N_CH  unsynchronised pin inputs
- clear  in  1  synchronous clear of last_valid
- level_out  out  N_CH  debounced, normalised level (1 = pressed)
- press_pulse  out  N_CH  1-cycle pulse per accepted press (and per repeat)
- release_pulse  out  N_CH  1-cycle pulse per accepted release
- last_idx  out  IDX_W  index of most recent press_pulse
- last_valid  out  1  a press occurred since reset/clear

## Operation
- Each channel uses a 2-flop synchroniser. It is then normalised: pressed = ACTIVE_LOW ? ~sync2 : sync2.
- Each channel has a DB counter of width $clog2(DB_CYCLES).
  - If normalised ≠ level_out, the counter increments.
  - If they are equal, the counter clears to 0.
  - When the counter = DB_CYCLES−1 and a mismatch persists, level_out toggles and the counter clears.
- On the same edge as a 0→1 toggle, press_pulse is set for one cycle. On a 1→0 toggle, release_pulse is set for one cycle. All outputs are registered.
- Any glitch shorter than DB_CYCLES cycles at sync2 produces no output change.
- last_idx/last_valid:
  - In any cycle where press_pulse ≠ 0, last_idx takes the lowest set index and last_valid becomes 1.
  - If press_pulse ≠ 0 and clear are both 1 in the same cycle, the press wins (last_valid = 1).
  - clear alone sets last_valid to 0; last_idx holds its value.
- Channels are fully independent; simultaneous events on several channels all appear in the same cycle.

## Timing
- Reset values:
  - Synchroniser flops reset to the released level (1 if ACTIVE_LOW, else 0), so a held-released pin causes no phantom press.
  - All counters reset to 0.
  - level_out, press_pulse, release_pulse, last_idx and last_valid reset to 0.
- Latency: the raw change is first sampled at edge E0. level_out and the pulse update at edge E(DB_CYCLES+1), i.e. DB_CYCLES+2 rising edges inclusive.
- Reset mid-operation: outputs clear immediately (asynchronous).
  - A key still held at deassert is accepted as a fresh press after the normal latency.
- Pulses are exactly one cycle wide. There are no back-to-back pulses on one channel without auto-repeat.

## Configuration
- KEY_AUTOREPEAT_EN defined:
  - Each channel has a repeat counter and a phase bit (DELAY/RATE), both cleared on the press event.
  - While level_out = 1, the counter increments each cycle. When it reaches REPEAT_DELAY−1 in DELAY phase, or REPEAT_RATE−1 in RATE phase, press_pulse fires, the counter clears and the phase becomes RATE.
  - Resulting events fall at t, t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_RATE, … where t is the press cycle.
  - A release clears the counter and phase immediately; no repeat pulse fires on the release edge.
  - Repeat pulses update last_idx like real presses.
- Undefined: no repeat counters are generated, REPEAT_* are ignored, and there is exactly one press_pulse per accepted press.

## Test plan
Bench parameters: N_CH=4, DB_CYCLES=8, ACTIVE_LOW=1, REPEAT_DELAY=32, REPEAT_RATE=8.
- Reset with raw_in=4'b1111, then deassert and idle 50 cycles -> all outputs 0, no pulses.
- raw_in[1] driven low for 5 cycles, then high -> level_out and pulses unchanged; counter returns to 0.
- raw_in[2] driven low, held 100 cycles, then high -> level_out[2] rises at edge 9 after first sample; press_pulse[2] high one cycle; last_idx=2, last_valid=1; release_pulse[2] one cycle after the same latency from release.
- raw_in[0] and raw_in[3] driven low on the same edge -> press_pulse=4'b1001 in one cycle; last_idx=0. Assert clear the next cycle -> last_valid=0.
- KEY_AUTOREPEAT_EN, raw_in[3] held 60 cycles past the press -> press_pulse[3] at relative cycles 0, 32, 40, 48, 56. Without the macro -> pulse at 0 only.
- Assert rst_flag while the raw_in[1] DB counter = 5 -> outputs 0 immediately. Keep the key held through deassert -> press_pulse[1] after the full 10-edge latency.

Source files
------------

// File: rtl/key_debounce_bank.sv
// Multi-channel key conditioner: 2-flop sync, polarity normalise, debounce, press/release events,
// last-pressed tracking. Define KEY_AUTOREPEAT_EN to add periodic repeat presses while a key is held.
module key_debounce_bank #(
  parameter int N_CH         = 4,
  parameter int DB_CYCLES    = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_flag,
  input  logic [N_CH-1:0]  raw_in,
  input  logic             clear,
  output logic [N_CH-1:0]  level_out,
  output logic [N_CH-1:0]  press_pulse,
  output logic [N_CH-1:0]  release_pulse,
  output logic [IDX_W-1:0] last_idx,
  output logic             last_valid
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [N_CH-1:0] RELEASED = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0]  sync1, sync2, norm, mism, flip, rep_fire;
  logic [CNT_W-1:0] db_cnt [N_CH];
  logic [IDX_W-1:0] low_idx;

  // Synchronisers start at the released level so an idle pin never looks like a press.
  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign norm = ACTIVE_LOW ? ~sync2 : sync2;
  assign mism = norm ^ level_out;

  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++)
      flip[i] = mism[i] && (db_cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
      level_out     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!mism[i] || flip[i]) db_cnt[i] <= '0;
        else                     db_cnt[i] <= db_cnt[i] + CNT_W'(1);
      end
      level_out     <= level_out ^ flip;
      press_pulse   <= (flip & ~level_out) | rep_fire;
      release_pulse <= flip & level_out;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] DELAY_END = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_END  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt [N_CH];
  logic [N_CH-1:0]  rep_phase;

  // A releasing channel (flip while level is high) must not repeat on that edge.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_CH; i++)
      rep_fire[i] = level_out[i] && !flip[i] &&
                    (rep_cnt[i] == (rep_phase[i] ? RATE_END : DELAY_END));
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      for (int i = 0; i < N_CH; i++) rep_cnt[i] <= '0;
      rep_phase <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!level_out[i] || flip[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b1;
        end else begin
          rep_cnt[i]   <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (press_pulse[i]) low_idx = IDX_W'(i);
  end

  // A visible press beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      last_idx   <= '0;
      last_valid <= 1'b0;
    end else if (|press_pulse) begin
      last_idx   <= low_idx;
      last_valid <= 1'b1;
    end else if (clear) begin
      last_valid <= 1'b0;
    end
  end

endmodule
